// File: rtl/inst_buffer_if.sv
// -----------------------------------------------------------------------------
// inst_buffer_if
//   Bundles the fetch-side and decode-side signals of the instruction buffer.
//   The buffer connects through the slave modport. Fetch/dispatch logic (or a
//   testbench) connects through the master modport.
//
//   flush      master->slave  discard every buffered entry
//   if_valid   master->slave  per-lane fetch valid, contiguous from lane 0
//   if_inst    master->slave  fetched instruction per lane
//   if_pc      master->slave  PC per fetch lane
//   if_ready   slave->master  fetch may enqueue this cycle
//   dec_valid  slave->master  per-decode-lane valid
//   dec_inst   slave->master  instruction per decode lane (NOP when invalid)
//   dec_pc     slave->master  PC per decode lane (0 when invalid)
//   dec_take   master->slave  number of head entries consumed this cycle
//   count      slave->master  current occupancy
// -----------------------------------------------------------------------------
interface inst_buffer_if #(
  parameter int DEPTH        = 8,
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int TAKE_W = $clog2(DECODE_WIDTH + 1);

  logic                          flush;
  logic [FETCH_WIDTH-1:0]        if_valid;
  logic [FETCH_WIDTH-1:0][31:0]  if_inst;
  logic [FETCH_WIDTH-1:0][31:0]  if_pc;
  logic                          if_ready;
  logic [DECODE_WIDTH-1:0]       dec_valid;
  logic [DECODE_WIDTH-1:0][31:0] dec_inst;
  logic [DECODE_WIDTH-1:0][31:0] dec_pc;
  logic [TAKE_W-1:0]             dec_take;
  logic [CNT_W-1:0]              count;

  modport master (
    output flush, if_valid, if_inst, if_pc, dec_take,
    input  if_ready, dec_valid, dec_inst, dec_pc, count
  );

  modport slave (
    input  flush, if_valid, if_inst, if_pc, dec_take,
    output if_ready, dec_valid, dec_inst, dec_pc, count
  );
endinterface

// File: rtl/inst_buffer.sv
// -----------------------------------------------------------------------------
// inst_buffer
//   Circular instruction queue between fetch and decode. Up to FETCH_WIDTH
//   instructions (with PCs) are enqueued per cycle; the oldest DECODE_WIDTH
//   entries are presented in program order to the decode lanes, and dispatch
//   releases them by reporting how many it took. Flush empties the queue.
//
//   clock    in   single clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of inst_buffer_if (fetch and decode signals)
// -----------------------------------------------------------------------------
module inst_buffer #(
  parameter int DEPTH        = 8,
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  inst_buffer_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENQ_W = $clog2(FETCH_WIDTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      instMem_q [DEPTH];
  logic [31:0]      pcMem_q   [DEPTH];
  logic [PTR_W-1:0] headPtr_q, headPtr_d;
  logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [ENQ_W-1:0] enqCount;
  logic             ifReady;
  logic             enqEn;

  // Ready looks only at the registered count, so a same-cycle dequeue can
  // never open the door early and the queue cannot overflow.
  assign ifReady      = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign enqEn        = ifReady && !bus.flush;
  assign bus.if_ready = ifReady;
  assign bus.count    = count_q;

  // Valid lanes are contiguous from lane 0, so the popcount is also the
  // number of slots the tail moves forward.
  always_comb begin
    enqCount = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (bus.if_valid[i]) enqCount = enqCount + ENQ_W'(1);
    end
  end

  // Next-state for pointers and occupancy; flush overrides both enqueue
  // and dequeue. Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    if (bus.flush) begin
      headPtr_d = '0;
      tailPtr_d = '0;
      count_d   = '0;
    end else begin
      headPtr_d = headPtr_q + PTR_W'(bus.dec_take);
      count_d   = count_q - CNT_W'(bus.dec_take);
      if (enqEn) begin
        tailPtr_d = tailPtr_q + PTR_W'(enqCount);
        count_d   = count_d + CNT_W'(enqCount);
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

  // Entry storage has no reset: contents outside [head, head+count) are
  // never presented, so stale data is harmless once the pointers clear.
  always_ff @(posedge clock) begin
    if (enqEn) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (bus.if_valid[i]) begin
          instMem_q[tailPtr_q + PTR_W'(i)] <= bus.if_inst[i];
          pcMem_q[tailPtr_q + PTR_W'(i)]   <= bus.if_pc[i];
        end
      end
    end
  end

  // Decode lanes read straight from storage (no bypass), so a freshly
  // written entry shows up the cycle after it is enqueued.
  always_comb begin
    bus.dec_valid = '0;
    bus.dec_inst  = '0;
    bus.dec_pc    = '0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      if (CNT_W'(j) < count_q) begin
        bus.dec_valid[j] = 1'b1;
        bus.dec_inst[j]  = instMem_q[headPtr_q + PTR_W'(j)];
        bus.dec_pc[j]    = pcMem_q[headPtr_q + PTR_W'(j)];
      end else begin
        bus.dec_inst[j]  = NOP;
        bus.dec_pc[j]    = 32'h0;
      end
    end
  end
endmodule

// File: tb/tb_inst_buffer.sv
// -----------------------------------------------------------------------------
// tb_inst_buffer
//   Directed testbench for inst_buffer. A queue-based scoreboard holds the
//   entries the buffer should contain; expected decode-lane contents, count
//   and if_ready are derived from it every cycle.
// -----------------------------------------------------------------------------
module tb_inst_buffer;
  localparam int DEPTH        = 8;
  localparam int FETCH_WIDTH  = 2;
  localparam int DECODE_WIDTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic   clock   = 1'b0;
  logic   reset_n = 1'b0;
  entry_t expQ[$];
  int     checks   = 0;
  int     failures = 0;
  logic [31:0] nextPc;
  logic [31:0] headPc;

  inst_buffer_if #(
    .DEPTH(DEPTH), .FETCH_WIDTH(FETCH_WIDTH), .DECODE_WIDTH(DECODE_WIDTH)
  ) bus ();

  inst_buffer #(
    .DEPTH(DEPTH), .FETCH_WIDTH(FETCH_WIDTH), .DECODE_WIDTH(DECODE_WIDTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mkInst(input logic [31:0] pc);
    return pc ^ 32'h5A30_0093;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Compares every DUT output against what the scoreboard says it holds.
  task automatic checkOutput();
    int n;
    n = expQ.size();
    checkValue("count", 32'(bus.count), 32'(n));
    checkValue("if_ready", 32'(bus.if_ready), (n <= DEPTH - FETCH_WIDTH) ? 32'd1 : 32'd0);
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      if (j < n) begin
        checkValue($sformatf("dec_valid[%0d]", j), 32'(bus.dec_valid[j]), 32'd1);
        checkValue($sformatf("dec_inst[%0d]", j), bus.dec_inst[j], expQ[j].inst);
        checkValue($sformatf("dec_pc[%0d]", j), bus.dec_pc[j], expQ[j].pc);
      end else begin
        checkValue($sformatf("dec_valid[%0d]", j), 32'(bus.dec_valid[j]), 32'd0);
        checkValue($sformatf("dec_inst[%0d]", j), bus.dec_inst[j], NOP);
        checkValue($sformatf("dec_pc[%0d]", j), bus.dec_pc[j], 32'h0);
      end
    end
  endtask

  // Drives one cycle of stimulus, updates the scoreboard, and advances to
  // #1 after the next rising edge with inputs returned to idle.
  task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] pc0,
                               input logic [31:0] pc1, input logic [1:0] take,
                               input logic fl);
    int  n;
    int  avail;
    bit  ready;
    n     = expQ.size();
    avail = (n < DECODE_WIDTH) ? n : DECODE_WIDTH;
    ready = (n <= DEPTH - FETCH_WIDTH);
    checkValue("stim_if_valid_contiguous", 32'(valid == 2'b10), 32'd0);
    checkValue("stim_dec_take_legal", 32'(int'(take) > avail), 32'd0);

    bus.if_valid   = valid;
    bus.if_inst[0] = mkInst(pc0);
    bus.if_inst[1] = mkInst(pc1);
    bus.if_pc[0]   = pc0;
    bus.if_pc[1]   = pc1;
    bus.dec_take   = take;
    bus.flush      = fl;

    if (fl) begin
      expQ.delete();
    end else begin
      for (int k = 0; k < int'(take); k++) void'(expQ.pop_front());
      if (ready) begin
        if (valid[0]) expQ.push_back('{inst: mkInst(pc0), pc: pc0});
        if (valid[1]) expQ.push_back('{inst: mkInst(pc1), pc: pc1});
      end
    end

    @(posedge clock);
    #1;
    bus.if_valid = '0;
    bus.dec_take = '0;
    bus.flush    = 1'b0;
  endtask

  initial begin
    bus.flush    = 1'b0;
    bus.if_valid = '0;
    bus.if_inst  = '0;
    bus.if_pc    = '0;
    bus.dec_take = '0;

    // Reset then idle: outputs clear immediately while reset is held.
    #1;
    checkOutput();
    checkValue("reset_dec_inst0_nop", bus.dec_inst[0], NOP);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    checkOutput();

    // Enqueue two, visible one cycle later, then consume both.
    applyStimulus(2'b11, 32'h0, 32'h4, 2'd0, 1'b0);
    checkOutput();
    checkValue("latency_count", 32'(bus.count), 32'd2);
    checkValue("latency_inst0", bus.dec_inst[0], mkInst(32'h0));
    applyStimulus(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    checkOutput();
    checkValue("drain_count", 32'(bus.count), 32'd0);

    // Fill until backpressure; ready stays up while count <= DEPTH-2.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(2'b11, 32'h40 + 32'(8 * c), 32'h44 + 32'(8 * c), 2'd0, 1'b0);
      checkOutput();
    end
    checkValue("full_count", 32'(bus.count), 32'd8);
    checkValue("full_if_ready", 32'(bus.if_ready), 32'd0);
    checkValue("full_dec_valid", 32'(bus.dec_valid), 32'd3);
    applyStimulus(2'b11, 32'h60, 32'h64, 2'd0, 1'b0);
    checkOutput();
    checkValue("dropped_count", 32'(bus.count), 32'd8);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    checkOutput();
    checkValue("reopen_if_ready", 32'(bus.if_ready), 32'd1);
    repeat (3) begin
      applyStimulus(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
      checkOutput();
    end

    // Wrap-around: enqueue 2 / dequeue 1 alternating across the pointer wrap.
    nextPc = 32'h0;
    headPc = 32'h0;
    for (int c = 0; c < 12; c++) begin
      if ((c % 2) == 0) begin
        applyStimulus(2'b11, nextPc, nextPc + 32'd4, 2'd0, 1'b0);
        nextPc = nextPc + 32'd8;
      end else begin
        applyStimulus(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
        headPc = headPc + 32'd4;
      end
      checkOutput();
      checkValue("wrap_head_pc", bus.dec_pc[0], headPc);
    end
    checkValue("wrap_count", 32'(bus.count), 32'd6);

    // Flush wins over a simultaneous enqueue and dequeue.
    applyStimulus(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
    checkValue("preflush_count", 32'(bus.count), 32'd5);
    applyStimulus(2'b11, 32'h80, 32'h84, 2'd2, 1'b1);
    checkOutput();
    checkValue("flush_count", 32'(bus.count), 32'd0);
    checkValue("flush_dec_valid", 32'(bus.dec_valid), 32'd0);
    checkValue("flush_if_ready", 32'(bus.if_ready), 32'd1);

    // Single-lane traffic.
    applyStimulus(2'b01, 32'h100, 32'h0, 2'd0, 1'b0);
    checkOutput();
    checkValue("single_dec_valid", 32'(bus.dec_valid), 32'd1);
    checkValue("single_inst1_nop", bus.dec_inst[1], NOP);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
    checkOutput();
    checkValue("single_inst1_nop_after", bus.dec_inst[1], NOP);

    // Same-cycle enqueue and dequeue are both honoured.
    applyStimulus(2'b11, 32'h180, 32'h184, 2'd0, 1'b0);
    checkOutput();
    applyStimulus(2'b11, 32'h188, 32'h18c, 2'd1, 1'b0);
    checkOutput();
    checkValue("simul_count", 32'(bus.count), 32'd3);
    checkValue("simul_head_pc", bus.dec_pc[0], 32'h184);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    checkOutput();
    applyStimulus(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
    checkOutput();

    // Reset mid-operation discards everything immediately.
    applyStimulus(2'b11, 32'h200, 32'h204, 2'd0, 1'b0);
    applyStimulus(2'b11, 32'h208, 32'h20c, 2'd0, 1'b0);
    checkOutput();
    reset_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    checkOutput();
    applyStimulus(2'b01, 32'h300, 32'h0, 2'd0, 1'b0);
    checkOutput();
    checkValue("post_reset_head_pc", bus.dec_pc[0], 32'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
